// File: rtl/oam_dma.sv
// oam_dma: CPU/DMA bus master mux plus OAM copy engine.
// A store to REG_ADDR copies LENGTH bytes from {page,8'h00} to DEST over the
// shared m_* bus, one READ / READ_LATENCY x WAIT / WRITE sequence per byte.
// Optional one-cycle completion pulse on 'done' when OAM_DMA_DONE_EN is defined.
module oam_dma #(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [15:0] REG_ADDR     = 16'hFF46,
  parameter logic [15:0] DEST         = 16'hFE00,
  parameter int unsigned LENGTH       = 160
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_indata,
  input  logic        cpu_load,
  input  logic        cpu_store,
  output logic [7:0]  cpu_outdata,
  output logic [15:0] m_address,
  output logic [7:0]  m_indata,
  output logic        m_load,
  output logic        m_store,
  input  logic [7:0]  m_outdata,
`ifdef OAM_DMA_DONE_EN
  output logic        done,
`endif
  output logic        busy
);

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned WAIT_W = 3;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LENGTH - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_WRITE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_REG, TAG_BLOCK} tag_t;

  state_t              state_q, state_d;
  logic [7:0]          src_page_q, src_page_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [7:0]          latch_q, latch_d;
  logic                busy_d;
  tag_t                tag_q [READ_LATENCY];
  tag_t                tag_in;
  logic                reg_hit;
  logic                reg_store;
  logic                last_byte;

  assign reg_hit   = (cpu_address == REG_ADDR);
  assign reg_store = cpu_store && reg_hit;
  assign last_byte = (index_q == LAST_IDX);

  // Classify this cycle's CPU load for the return-data pipeline.
  always_comb begin
    tag_in = TAG_NONE;
    if (cpu_load) begin
      if (busy)         tag_in = TAG_BLOCK;
      else if (reg_hit) tag_in = TAG_REG;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      src_page_q <= 8'h00;
      index_q    <= '0;
      wait_q     <= '0;
      latch_q    <= 8'h00;
      busy       <= 1'b0;
      for (int k = 0; k < int'(READ_LATENCY); k++) tag_q[k] <= TAG_NONE;
    end else begin
      state_q    <= state_d;
      src_page_q <= src_page_d;
      index_q    <= index_d;
      wait_q     <= wait_d;
      latch_q    <= latch_d;
      busy       <= busy_d;
      for (int k = 1; k < int'(READ_LATENCY); k++) tag_q[k] <= tag_q[k-1];
      tag_q[0] <= tag_in;
    end
  end

  // Next-state logic and shared-bus drive; a register store always (re)starts.
  always_comb begin
    state_d    = state_q;
    src_page_d = src_page_q;
    index_d    = index_q;
    wait_d     = wait_q;
    latch_d    = latch_q;
    busy_d     = busy;
    m_address  = cpu_address;
    m_indata   = cpu_indata;
    m_load     = cpu_load;
    m_store    = cpu_store && !reg_hit;
    case (state_q)
      S_IDLE: ;
      S_READ: begin
        m_address = {src_page_q, index_q};
        m_indata  = latch_q;
        m_load    = 1'b1;
        m_store   = 1'b0;
        wait_d    = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        m_address = {src_page_q, index_q};
        m_indata  = latch_q;
        m_load    = 1'b0;
        m_store   = 1'b0;
        if (wait_q == LAST_WAIT) begin
          latch_d = m_outdata;
          state_d = S_WRITE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITE: begin
        m_address = DEST + 16'(index_q);
        m_indata  = latch_q;
        m_load    = 1'b0;
        m_store   = 1'b1;
        if (last_byte) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reg_store) begin
      src_page_d = cpu_indata;
      index_d    = '0;
      wait_d     = '0;
      state_d    = S_READ;
      busy_d     = 1'b1;
    end
  end

  // Return data selected by the tag that has aged READ_LATENCY cycles.
  always_comb begin
    case (tag_q[READ_LATENCY-1])
      TAG_REG:   cpu_outdata = src_page_q;
      TAG_BLOCK: cpu_outdata = 8'hFF;
      default:   cpu_outdata = m_outdata;
    endcase
  end

`ifdef OAM_DMA_DONE_EN
  // Completion pulse after the final write, suppressed by a same-cycle restart.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) done <= 1'b0;
    else         done <= (state_q == S_WRITE) && last_byte && !reg_store;
  end
`endif

endmodule
